// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle controller sitting between the instruction source and the
// operand-register / ALU datapath. It accepts one 39-bit instruction at a
// time, decodes the opcode in [38:36], and then does one of two things:
//   - load/clear opcodes (000, 001, 010): pulses the matching operand
//     register strobe for one cycle and returns to IDLE;
//   - ALU opcodes (011..111): reads both operand registers, starts the ALU,
//     waits for alu_done (bounded by TIMEOUT cycles), and returns the result.
//
// Parameters:
//   TIMEOUT      cycles spent in WAIT without alu_done before aborting (>=1)
//   CNT_W        width of the completed-instruction counter
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   instr        instruction: [38:36] opcode, [35:32] ignored, [31:0] data
//   instr_valid  instr is valid this cycle
//   instr_ready  sequencer can accept (high only in IDLE)
//   write_A/B    one-cycle load strobes for operand registers A/B
//   reset_A/B    clear strobes for operand registers A/B
//   read_A/B     one-cycle read strobes for operand registers A/B
//   operand      registered copy of instr[31:0]
//   alu_op       registered opcode
//   alu_start    one-cycle ALU start pulse
//   alu_done     ALU completion (level or pulse)
//   alu_result   ALU result, valid while alu_done is high
//   result       captured ALU result
//   result_valid one-cycle pulse when result is updated
//   busy         high in any state other than IDLE
//   timeout_err  sticky flag, set when the ALU fails to answer in time
//   instr_count  completed instructions, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [38:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             write_A,
  output logic             write_B,
  output logic             reset_A,
  output logic             reset_B,
  output logic             read_A,
  output logic             read_B,
  output logic [31:0]      operand,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [31:0]      alu_result,
  output logic [31:0]      result,
  output logic             result_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  // The wait counter only has to reach TIMEOUT-1: the abort is taken on the
  // edge that ends the TIMEOUT-th WAIT cycle.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  // instr[35:32] carry no meaning for this block.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[35:32]};

  // Handshake and activity flags are pure state decodes so that a new
  // instruction can be offered the very cycle the sequencer returns to IDLE.
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Main sequencer. Strobes are registered, so the decision to raise a
  // strobe is made on the accepting edge; that places the strobe exactly in
  // the DISPATCH cycle. Every strobe defaults low each cycle, which is also
  // what drops reset_A/reset_B on the first edge after reset releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      reset_A      <= 1'b1;
      reset_B      <= 1'b1;
      write_A      <= 1'b0;
      write_B      <= 1'b0;
      read_A       <= 1'b0;
      read_B       <= 1'b0;
      alu_start    <= 1'b0;
      operand      <= '0;
      alu_op       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      instr_count  <= '0;
    end else begin
      reset_A      <= 1'b0;
      reset_B      <= 1'b0;
      write_A      <= 1'b0;
      write_B      <= 1'b0;
      read_A       <= 1'b0;
      read_B       <= 1'b0;
      alu_start    <= 1'b0;
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (instr_valid) begin
            operand <= instr[31:0];
            alu_op  <= instr[38:36];
            state   <= DISPATCH;
            case (instr[38:36])
              3'b000: begin
                reset_A <= 1'b1;
                reset_B <= 1'b1;
              end
              3'b001: write_A <= 1'b1;
              3'b010: write_B <= 1'b1;
              default: begin
                read_A    <= 1'b1;
                read_B    <= 1'b1;
                alu_start <= 1'b1;
              end
            endcase
          end
        end

        // Load/clear opcodes complete here; ALU opcodes move on to WAIT
        // with a fresh wait counter. alu_done is deliberately not looked at.
        DISPATCH: begin
          if (alu_op < 3'd3) begin
            instr_count <= instr_count + CNT_W'(1);
            state       <= IDLE;
          end else begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end

        // Completion wins over timeout if both happen on the same edge.
        WAIT: begin
          if (alu_done) begin
            result       <= alu_result;
            result_valid <= 1'b1;
            state        <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        DONE: begin
          instr_count <= instr_count + CNT_W'(1);
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
